// File: rtl/uart_cmd_pkg.sv
// Shared constants, ack state encoding and the case-fold helper for the
// UART command decoder.
package uart_cmd_pkg;

  localparam logic [7:0] ASC_ESC   = 8'h1B;
  localparam logic [7:0] ASC_C     = 8'h43;
  localparam logic [7:0] ASC_G     = 8'h47;
  localparam logic [7:0] ASC_W     = 8'h57;
  localparam logic [7:0] ASC_D     = 8'h44;
  localparam logic [7:0] ASC_M_LC  = 8'h6D;
  localparam logic [7:0] ASC_N_LC  = 8'h6E;
  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_1     = 8'h31;
  localparam logic [7:0] ASC_2     = 8'h32;
  localparam logic [7:0] ASC_3     = 8'h33;
  localparam logic [7:0] ASC_QMARK = 8'h3F;

  // Width of the button channel index (up to 8 channels).
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_SEND = 2'd2
  } ack_state_t;

  // Map 'a'..'z' onto 'A'..'Z'; every other byte passes through.
  function automatic logic [7:0] to_upper(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
    return b;
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Byte-level link between uart_rx/uart_tx and the command decoder.
// master: the UART side; slave: the decoder.
interface uart_cmd_decoder_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;

  modport master (output rx_data, rx_done, tx_busy, input tx_start, tx_data);
  modport slave  (input rx_data, rx_done, tx_busy, output tx_start, tx_data);
endinterface

// File: rtl/uart_cmd_pulse.sv
// Button pulse stretcher: a load selects one channel and holds it high for
// PULSE_LEN cycles; a new load retargets and restarts the count.
module uart_cmd_pulse
  import uart_cmd_pkg::*;
#(
  parameter int N_BTN     = 5,
  parameter int PULSE_LEN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [IDX_W-1:0] idx,
  output logic [N_BTN-1:0] pulse
);

  logic [N_BTN-1:0] pulse_q, pulse_d;
  logic [7:0]       cnt_q, cnt_d;

  // Next-state: cnt_q is the number of cycles still to run after this one.
  always_comb begin
    pulse_d = pulse_q;
    cnt_d   = cnt_q;
    if (load) begin
      pulse_d = '0;
      for (int i = 0; i < N_BTN; i++) begin
        if (IDX_W'(i) == idx) pulse_d[i] = 1'b1;
      end
      cnt_d = 8'(PULSE_LEN - 1);
    end else if (pulse_q != '0) begin
      if (cnt_q == 8'd0) pulse_d = '0;
      else               cnt_d   = cnt_q - 8'd1;
    end
  end

  // Pulse and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_q <= '0;
      cnt_q   <= '0;
    end else begin
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/uart_cmd_decoder.sv
// UART command decoder: turns received bytes into button pulses, switch
// toggles or a clear-all, and optionally echoes an ack byte to uart_tx.
// Optional feature macro: UART_CMD_ACK_EN (builds the ack FSM).
//
// Ack FSM states:
//   state   | meaning
//   ST_IDLE | nothing to acknowledge
//   ST_PEND | ack byte in tx_data, waiting for tx_busy low to start
//   ST_SEND | tx_start issued, tx_data held until uart_tx is free again
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int                  N_BTN     = 5,
  parameter int                  N_SW      = 5,
  parameter logic [8*N_BTN-1:0]  BTN_CODES = 40'h44_57_47_43_1B,
  parameter logic [8*N_SW-1:0]   SW_CODES  = 40'h33_32_31_6E_6D,
  parameter logic [7:0]          CLR_CODE  = 8'h30,
  parameter logic [N_SW-1:0]     SW_INIT   = '0,
  parameter int                  PULSE_LEN = 1,
  parameter int                  CASE_FOLD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_cmd_decoder_if.slave    bus,
  output logic [N_BTN-1:0]     btn_pulse,
  output logic [N_SW-1:0]      sw_out,
  output logic                 cmd_err
);

  function automatic logic [7:0] fold_byte(input logic [7:0] b);
    if (CASE_FOLD != 0) return to_upper(b);
    return b;
  endfunction

  logic [7:0]       key;
  logic             clr_hit;
  logic [N_BTN-1:0] btn_hit;
  logic [N_SW-1:0]  sw_hit;

  assign key     = fold_byte(bus.rx_data);
  assign clr_hit = bus.rx_done && (key == fold_byte(CLR_CODE));

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn_match
    assign btn_hit[gi] = bus.rx_done && (key == fold_byte(BTN_CODES[8*gi +: 8]));
  end

  for (genvar gj = 0; gj < N_SW; gj++) begin : g_sw_match
    assign sw_hit[gj] = bus.rx_done && (key == fold_byte(SW_CODES[8*gj +: 8]));
  end

  logic             btn_any, sw_any, hit_any;
  logic [IDX_W-1:0] btn_idx;
  logic [N_SW-1:0]  sw_tog;
  logic [7:0]       ack_byte;

  // Lowest-index priority within each table (scan downward, last hit wins).
  always_comb begin
    btn_any = 1'b0;
    btn_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (btn_hit[i]) begin
        btn_any = 1'b1;
        btn_idx = IDX_W'(i);
      end
    end
    sw_any = 1'b0;
    sw_tog = '0;
    for (int j = N_SW - 1; j >= 0; j--) begin
      if (sw_hit[j]) begin
        sw_any    = 1'b1;
        sw_tog    = '0;
        sw_tog[j] = 1'b1;
      end
    end
  end

  assign hit_any  = clr_hit || btn_any || sw_any;
  assign ack_byte = hit_any ? bus.rx_data : ASC_QMARK;

  logic [N_SW-1:0] sw_q, sw_d;
  logic            err_q, err_d;
  logic            btn_load;

  // Command dispatch: clear beats buttons, buttons beat switches.
  always_comb begin
    sw_d     = sw_q;
    err_d    = 1'b0;
    btn_load = 1'b0;
    if (clr_hit)          sw_d     = SW_INIT;
    else if (btn_any)     btn_load = 1'b1;
    else if (sw_any)      sw_d     = sw_q ^ sw_tog;
    else if (bus.rx_done) err_d    = 1'b1;
  end

  // Switch state and error strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_q  <= SW_INIT;
      err_q <= 1'b0;
    end else begin
      sw_q  <= sw_d;
      err_q <= err_d;
    end
  end

  uart_cmd_pulse #(
    .N_BTN     (N_BTN),
    .PULSE_LEN (PULSE_LEN)
  ) u_pulse (
    .clk   (clk),
    .rst   (rst),
    .load  (btn_load),
    .idx   (btn_idx),
    .pulse (btn_pulse)
  );

  assign sw_out  = sw_q;
  assign cmd_err = err_q;

`ifdef UART_CMD_ACK_EN
  ack_state_t state_q, state_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [7:0] pend_data_q, pend_data_d;
  logic       pend_q, pend_d;
  logic       tx_start_q, tx_start_d;
  logic [1:0] hold_q, hold_d;

  // Ack FSM next-state; hold_q counts down the minimum SEND residency.
  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    pend_data_d = pend_data_q;
    pend_d      = pend_q;
    tx_start_d  = 1'b0;
    hold_d      = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.rx_done) begin
          tx_data_d = ack_byte;
          state_d   = ST_PEND;
        end
      end
      ST_PEND: begin
        if (bus.rx_done) tx_data_d = ack_byte;
        if (!bus.tx_busy) begin
          tx_start_d = 1'b1;
          hold_d     = 2'd2;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (hold_q != 2'd0) hold_d = hold_q - 2'd1;
        if (bus.rx_done) begin
          pend_d      = 1'b1;
          pend_data_d = ack_byte;
        end
        if (hold_q == 2'd0 && !bus.tx_busy) begin
          pend_d = 1'b0;
          if (bus.rx_done) begin
            tx_data_d = ack_byte;
            state_d   = ST_PEND;
          end else if (pend_q) begin
            tx_data_d = pend_data_q;
            state_d   = ST_PEND;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ack FSM registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tx_data_q   <= 8'h00;
      pend_data_q <= 8'h00;
      pend_q      <= 1'b0;
      tx_start_q  <= 1'b0;
      hold_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      tx_data_q   <= tx_data_d;
      pend_data_q <= pend_data_d;
      pend_q      <= pend_d;
      tx_start_q  <= tx_start_d;
      hold_q      <= hold_d;
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
`else
  logic unused_tx;
  assign unused_tx    = bus.tx_busy ^ (|ack_byte);
  assign bus.tx_start = 1'b0;
  assign bus.tx_data  = 8'h00;
`endif

endmodule
